card_mailbox: RTL
=================

# card_mailbox

Slot I/O mailbox between 6502 boot code running from the card ROM and FPGA-side logic. The 6502 posts bytes into a host-to-FPGA FIFO and reads bytes back from an FPGA-to-host FIFO via four registers in the slot's $C0n0 device-select space. Writing a release command there, once the FPGA has drained the command FIFO, raises the ROM-release request that hands $F000–$FFFF back to the motherboard ROM. Sits on `a2bus_if` alongside the card ROM responder, whose `req_rom_release_i` it drives.

## Interface
- `SLOT`, default 7: slot number; decode base = $C080 + SLOT*16.
- `DEPTH`, default 4: entries per FIFO, power of two, 2..16.
- `RELEASE_CMD`, default 8'hA5: CTRL value that requests ROM release.

Ports:
- `a2bus_if.clk_logic`  in  1  single clock; all state on its rising edge.
- `a2bus_if.system_reset_n`  in  1  asynchronous active-low reset.
- `a2bus_if`  slave  –  uses `addr[15:0]`, `data[7:0]`, `rw_n`, `phi0`.
- `h2f_data_o`  out  8  head of host-to-FPGA FIFO.
- `h2f_valid_o`  out  1  head valid.
- `h2f_ready_i`  in  1  pop when valid & ready.
- `f2h_data_i`  in  8  byte for FPGA-to-host FIFO.
- `f2h_valid_i`  in  1  push request.
- `f2h_ready_o`  out  1  FIFO not full.
- `data_o`  out  8  read data to bus.
- `rd_en_o`  out  1  drive bus: decode hit & `rw_n` & `phi0`.
- `req_rom_release_o`  out  1  sticky ROM-release request.

## Operation
- Decode hit: `addr[15:4]` == base[15:4], `addr[3:2]` == 0. Offsets: +0 TXDATA (W), +1 RXDATA (R), +2 STATUS (R), +3 CTRL (W). Writes to read-only offsets and reads of write-only offsets have no side effect; reads of +0/+3 return STATUS.
- Bus cycle end: `phi0` registered once; end = phi0_q & !phi0. All 6502-side side effects (push, pop, CTRL) happen only on the end cycle, using `addr`, `data`, `rw_n` sampled that cycle. Exactly one side effect per bus cycle.
- TXDATA write: push `data` into H2F if not full; if full, byte dropped, sticky `ovf` set.
- RXDATA read: `data_o` = F2H head (00 if empty); pop at cycle end if non-empty.
- STATUS: bit0 H2F full, bit1 F2H non-empty, bit2 `ovf`, bit6 release pending, bit7 `req_rom_release_o`; others 0. Reading STATUS clears `ovf` at cycle end.
- CTRL write of `RELEASE_CMD` sets pending; other values clear pending (unless already released).
- Release FSM: IDLE → PENDING (CTRL = RELEASE_CMD) → RELEASED when H2F empty and no push this cycle. RELEASED is terminal until reset; `req_rom_release_o` = (state == RELEASED).
- FIFOs: circular buffers with `$clog2(DEPTH)+1`-bit pointers; full = MSBs differ, low bits equal. Simultaneous push and pop on a full or empty FIFO: pop is evaluated first for full (push accepted), push first for empty (head not valid until next cycle).

## Timing
- Reset (async assert, synchronous deassert handled upstream): both FIFOs empty, `ovf`=0, FSM IDLE, phi0_q=0; `h2f_valid_o`=0, `h2f_data_o`=00, `f2h_ready_o`=1, `req_rom_release_o`=0, `rd_en_o` follows decode, `data_o`=STATUS reset value 00.
- Push → `h2f_valid_o` on the next cycle. FPGA pop → 6502-visible STATUS the next cycle.
- `data_o` combinational from current addr and FIFO head; stable through the phi0-high window.
- RELEASED reached ≥1 cycle after the H2F FIFO empties; `req_rom_release_o` never deasserts except by reset.
- Reset mid-bus-cycle: no pending side effect survives; phi0_q restart prevents a spurious cycle end.

## Configuration
- `CARD_MAILBOX_F2H_EN`: defined → F2H FIFO built as above. Undefined → no F2H storage; `f2h_ready_o`=0, RXDATA reads 00 with no pop, STATUS bit1=0.

## Test plan
- Write $11,$22,$33 to $C0F0 (SLOT 7), `h2f_ready_i`=1 → `h2f_data_o` 11,22,33 in order, one per cycle, `h2f_valid_o` then 0.
- With `h2f_ready_i`=0, five writes → four retained, STATUS=$05; STATUS read once → next STATUS=$01.
- `f2h_valid_i` with $5A, $A5 → STATUS bit1=1; RXDATA reads return 5A then A5, then 00 with STATUS bit1=0.
- Write $A5 to $C0F3 with two bytes queued → STATUS=$40; after FPGA pops both → `req_rom_release_o`=1 one cycle later, STATUS=$80.
- Write $A5 then $00 to CTRL before drain → no release; reset asserted with pending → all outputs at reset values immediately.
- Macro undefined: `f2h_valid_i` pulses → `f2h_ready_o`=0, RXDATA reads 00.

Source files
------------

// File: rtl/card_mailbox_if.sv
// Apple II slot bus as seen by a card-side responder: clock, reset, address,
// write data, direction and phi0.
interface a2bus_if;
    logic        clk_logic;
    logic        system_reset_n;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n;
    logic        phi0;

    modport master (output clk_logic, system_reset_n, addr, data, rw_n, phi0);
    modport slave  (input  clk_logic, system_reset_n, addr, data, rw_n, phi0);
endinterface

// File: rtl/card_mailbox.sv
// 6502 <-> FPGA byte mailbox in the slot device-select space, with a sticky
// ROM-release request. Optional FPGA-to-host FIFO: CARD_MAILBOX_F2H_EN.
module card_mailbox #(
    parameter int         SLOT        = 7,
    parameter int         DEPTH       = 4,
    parameter logic [7:0] RELEASE_CMD = 8'hA5
) (
    a2bus_if.slave bus,
    output logic [7:0] h2f_data_o,
    output logic       h2f_valid_o,
    input  logic       h2f_ready_i,
    input  logic [7:0] f2h_data_i,
    input  logic       f2h_valid_i,
    output logic       f2h_ready_o,
    output logic [7:0] data_o,
    output logic       rd_en_o,
    output logic       req_rom_release_o
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [15:0] BASE = 16'hC080 + 16'(SLOT * 16);

    typedef enum logic [1:0] {IDLE, PENDING, RELEASED} state_e;

    logic       clk, rst_n;
    logic       phi0_q, phi0_d;
    logic       ovf_q, ovf_d;
    state_e     state_q, state_d;
    logic       hit, cyc_end, tx_wr, ctrl_wr, rx_rd, st_rd;
    logic [7:0] status, rx_data;
    logic       f2h_nonempty;

    assign clk   = bus.clk_logic;
    assign rst_n = bus.system_reset_n;

    // Bus cycle ends on the falling edge of phi0; all 6502 side effects land here.
    assign hit     = (bus.addr[15:4] == BASE[15:4]) && (bus.addr[3:2] == 2'b00);
    assign cyc_end = phi0_q & ~bus.phi0;
    assign tx_wr   = cyc_end & hit & ~bus.rw_n & (bus.addr[1:0] == 2'd0);
    assign rx_rd   = cyc_end & hit &  bus.rw_n & (bus.addr[1:0] == 2'd1);
    assign st_rd   = cyc_end & hit &  bus.rw_n & (bus.addr[1:0] == 2'd2);
    assign ctrl_wr = cyc_end & hit & ~bus.rw_n & (bus.addr[1:0] == 2'd3);
    assign phi0_d  = bus.phi0;

    // Host-to-FPGA FIFO
    logic [AW:0] h2f_wr_q, h2f_wr_d, h2f_rd_q, h2f_rd_d;
    logic [7:0]  h2f_mem_q [DEPTH];
    logic [7:0]  h2f_mem_d [DEPTH];
    logic        h2f_empty, h2f_full, h2f_push, h2f_pop;

    assign h2f_empty   = (h2f_wr_q == h2f_rd_q);
    assign h2f_full    = (h2f_wr_q[AW] != h2f_rd_q[AW]) && (h2f_wr_q[AW-1:0] == h2f_rd_q[AW-1:0]);
    assign h2f_pop     = ~h2f_empty & h2f_ready_i;
    // A pop frees the slot first, so a write to a full FIFO that is draining is kept.
    assign h2f_push    = tx_wr & (~h2f_full | h2f_pop);
    assign h2f_valid_o = ~h2f_empty;
    assign h2f_data_o  = h2f_empty ? 8'h00 : h2f_mem_q[h2f_rd_q[AW-1:0]];

    always_comb begin
        h2f_mem_d = h2f_mem_q;
        h2f_wr_d  = h2f_wr_q;
        h2f_rd_d  = h2f_rd_q;
        ovf_d     = ovf_q;
        if (h2f_push) begin
            h2f_mem_d[h2f_wr_q[AW-1:0]] = bus.data;
            h2f_wr_d = h2f_wr_q + 1'b1;
        end
        if (h2f_pop)
            h2f_rd_d = h2f_rd_q + 1'b1;
        if (tx_wr && !h2f_push)
            ovf_d = 1'b1;
        else if (st_rd)
            ovf_d = 1'b0;
    end

`ifdef CARD_MAILBOX_F2H_EN
    // FPGA-to-host FIFO; the producer only pushes against an advertised ready.
    logic [AW:0] f2h_wr_q, f2h_wr_d, f2h_rd_q, f2h_rd_d;
    logic [7:0]  f2h_mem_q [DEPTH];
    logic [7:0]  f2h_mem_d [DEPTH];
    logic        f2h_full, f2h_push, f2h_pop;

    assign f2h_nonempty = (f2h_wr_q != f2h_rd_q);
    assign f2h_full     = (f2h_wr_q[AW] != f2h_rd_q[AW]) && (f2h_wr_q[AW-1:0] == f2h_rd_q[AW-1:0]);
    assign f2h_ready_o  = ~f2h_full;
    assign f2h_push     = f2h_valid_i & ~f2h_full;
    assign f2h_pop      = rx_rd & f2h_nonempty;
    assign rx_data      = f2h_nonempty ? f2h_mem_q[f2h_rd_q[AW-1:0]] : 8'h00;

    always_comb begin
        f2h_mem_d = f2h_mem_q;
        f2h_wr_d  = f2h_wr_q;
        f2h_rd_d  = f2h_rd_q;
        if (f2h_push) begin
            f2h_mem_d[f2h_wr_q[AW-1:0]] = f2h_data_i;
            f2h_wr_d = f2h_wr_q + 1'b1;
        end
        if (f2h_pop)
            f2h_rd_d = f2h_rd_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f2h_wr_q <= '0;
            f2h_rd_q <= '0;
        end else begin
            f2h_wr_q <= f2h_wr_d;
            f2h_rd_q <= f2h_rd_d;
        end
    end

    always_ff @(posedge clk)
        f2h_mem_q <= f2h_mem_d;
`else
    logic f2h_unused;
    assign f2h_unused   = ^{f2h_data_i, f2h_valid_i, rx_rd};
    assign f2h_nonempty = 1'b0;
    assign f2h_ready_o  = 1'b0;
    assign rx_data      = 8'h00;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:
                if (ctrl_wr && bus.data == RELEASE_CMD)
                    state_d = PENDING;
            PENDING:
                if (ctrl_wr && bus.data != RELEASE_CMD)
                    state_d = IDLE;
                else if (h2f_empty && !h2f_push)
                    state_d = RELEASED;
            RELEASED:
                state_d = RELEASED;
            default:
                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phi0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            h2f_wr_q <= '0;
            h2f_rd_q <= '0;
        end else begin
            phi0_q   <= phi0_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            h2f_wr_q <= h2f_wr_d;
            h2f_rd_q <= h2f_rd_d;
        end
    end

    always_ff @(posedge clk)
        h2f_mem_q <= h2f_mem_d;

    assign req_rom_release_o = (state_q == RELEASED);
    assign status  = {req_rom_release_o, state_q == PENDING, 3'b000, ovf_q, f2h_nonempty, h2f_full};
    assign data_o  = (bus.addr[1:0] == 2'd1) ? rx_data : status;
    assign rd_en_o = hit & bus.rw_n & bus.phi0;
endmodule
